pmod_ssd_decoder: RTL

Receive-side counterpart of the Pmod seven-segment display driver. Samples the multiplexed two-digit segment bus (7 segment lines plus digit select), waits for each digit phase to settle, decodes each segment pattern back to a hex nibble and reassembles the 8-bit displayed value. Used in loopback self-test and to monitor an external Pmod SSD bus.

---
 rtl/pmod_ssd_decoder.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pmod_ssd_decoder.sv
// Receive-side decoder for a multiplexed two-digit Pmod seven-segment bus.
// Optional macro SSD_DECODER_CHANGE_ONLY_EN suppresses value_valid for repeated bytes.
module pmod_ssd_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] segments_in,
  input  logic       digit_select_in,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       code_error,
  output logic       link_active
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETTLE    = 2'd1,
    CAPTURE   = 2'd2,
    WAIT_EDGE = 2'd3
  } state_e;

  // Returns {legal, nibble} for a segment pattern
  function automatic logic [4:0] glyph_decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h7B:   r = {1'b1, 4'h0};
      7'h30:   r = {1'b1, 4'h1};
      7'h5D:   r = {1'b1, 4'h2};
      7'h7C:   r = {1'b1, 4'h3};
      7'h36:   r = {1'b1, 4'h4};
      7'h6E:   r = {1'b1, 4'h5};
      7'h6F:   r = {1'b1, 4'h6};
      7'h38:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h7E:   r = {1'b1, 4'h9};
      7'h3F:   r = {1'b1, 4'hA};
      7'h67:   r = {1'b1, 4'hB};
      7'h4B:   r = {1'b1, 4'hC};
      7'h75:   r = {1'b1, 4'hD};
      7'h4F:   r = {1'b1, 4'hE};
      7'h0F:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  logic [6:0]    seg_meta_q, seg_s_q;
  logic          dsel_meta_q, dsel_s_q, dsel_prev_q;
  state_e        state_q, state_d;
  logic [6:0]    seg_ref_q, seg_ref_d;
  logic          dsel_ref_q, dsel_ref_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    hi_q, hi_d, lo_q, lo_d;
  logic          have_hi_q, have_hi_d, have_lo_q, have_lo_d;
  logic [7:0]    value_q, value_d;
  logic          valid_q, valid_d, err_q, err_d, link_q, link_d;
  logic [7:0]    pair_s;
  logic          edge_s, seg_match_s, timeout_s, glyph_legal_s;
  logic [3:0]    glyph_nib_s;
`ifdef SSD_DECODER_CHANGE_ONLY_EN
  logic          first_q, first_d;
`endif

  assign edge_s      = dsel_s_q ^ dsel_prev_q;
  assign seg_match_s = (seg_s_q == seg_ref_q);
  assign timeout_s   = !edge_s && (tcnt_q == TIMEOUT_LAST);
  assign {glyph_legal_s, glyph_nib_s} = glyph_decode(seg_ref_q);

  // Two-flop synchronizers and digit-select history for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_meta_q  <= '0;
      seg_s_q     <= '0;
      dsel_meta_q <= 1'b0;
      dsel_s_q    <= 1'b0;
      dsel_prev_q <= 1'b0;
    end else begin
      seg_meta_q  <= segments_in;
      seg_s_q     <= seg_meta_q;
      dsel_meta_q <= digit_select_in;
      dsel_s_q    <= dsel_meta_q;
      dsel_prev_q <= dsel_s_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: an edge restarts settling from any state
  always_comb begin
    state_d = state_q;
    if (edge_s) begin
      state_d = SETTLE;
    end else if (timeout_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      state_d = IDLE;
        SETTLE:    state_d = (seg_match_s && (cnt_q == SETTLE_LAST)) ? CAPTURE : SETTLE;
        CAPTURE:   state_d = WAIT_EDGE;
        WAIT_EDGE: state_d = WAIT_EDGE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Timeout counter: cleared by edges, saturating at the limit
  always_comb begin
    if (edge_s) begin
      tcnt_d = '0;
    end else if (tcnt_q == TIMEOUT_MAX) begin
      tcnt_d = tcnt_q;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  // Datapath and output next-state: settle tracking, capture, pair assembly
  always_comb begin
    seg_ref_d  = seg_ref_q;
    dsel_ref_d = dsel_ref_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    have_hi_d  = have_hi_q;
    have_lo_d  = have_lo_q;
    value_d    = value_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    link_d     = link_q;
    pair_s     = {hi_q, lo_q};
`ifdef SSD_DECODER_CHANGE_ONLY_EN
    first_d    = first_q;
`endif

    if (edge_s) begin
      seg_ref_d  = seg_s_q;
      dsel_ref_d = dsel_s_q;
      cnt_d      = '0;
    end else if (state_q == SETTLE) begin
      if (seg_match_s) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        seg_ref_d = seg_s_q;
        cnt_d     = '0;
      end
    end else begin
      cnt_d = cnt_q;
    end

    // The slot comes from dsel_ref so a capture overlapping the next edge lands correctly
    if (timeout_s) begin
      link_d    = 1'b0;
      have_hi_d = 1'b0;
      have_lo_d = 1'b0;
`ifdef SSD_DECODER_CHANGE_ONLY_EN
      first_d   = 1'b1;
`endif
    end else if (state_q == CAPTURE) begin
      if (glyph_legal_s) begin
        link_d = 1'b1;
        if (dsel_ref_q) begin
          hi_d      = glyph_nib_s;
          have_hi_d = 1'b1;
        end else begin
          lo_d      = glyph_nib_s;
          have_lo_d = 1'b1;
        end
        pair_s = {hi_d, lo_d};
        if (have_hi_d && have_lo_d) begin
          have_hi_d = 1'b0;
          have_lo_d = 1'b0;
`ifdef SSD_DECODER_CHANGE_ONLY_EN
          if (first_q || (pair_s != value_q)) begin
            value_d = pair_s;
            valid_d = 1'b1;
            first_d = 1'b0;
          end else begin
            value_d = value_q;
          end
`else
          value_d = pair_s;
          valid_d = 1'b1;
`endif
        end else begin
          value_d = value_q;
        end
      end else begin
        err_d     = 1'b1;
        have_hi_d = 1'b0;
        have_lo_d = 1'b0;
      end
    end else begin
      link_d = link_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_ref_q  <= '0;
      dsel_ref_q <= 1'b0;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      hi_q       <= 4'h0;
      lo_q       <= 4'h0;
      have_hi_q  <= 1'b0;
      have_lo_q  <= 1'b0;
      value_q    <= 8'h00;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      link_q     <= 1'b0;
`ifdef SSD_DECODER_CHANGE_ONLY_EN
      first_q    <= 1'b1;
`endif
    end else begin
      seg_ref_q  <= seg_ref_d;
      dsel_ref_q <= dsel_ref_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      have_hi_q  <= have_hi_d;
      have_lo_q  <= have_lo_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      link_q     <= link_d;
`ifdef SSD_DECODER_CHANGE_ONLY_EN
      first_q    <= first_d;
`endif
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign code_error  = err_q;
  assign link_active = link_q;

endmodule
